pipe_id_regread: RTL and testbench

// - ID-stage reader of the write-back interface: holds the 32-entry GPR file written by WB
//   (wwreg/wrn/wdi), provides both ID operands, and decides forwarding and load-use stall.
// - Sits between the IF/ID and ID/EXE pipeline registers; wpcir gates PC and IF/ID updates.
// - Also keeps a saturating count of load-use stall cycles for performance debugging.

---
 rtl/pipe_id_regread_pkg.sv | 32 +++
 rtl/pipe_id_regread_gpr_file.sv | 56 +++++
 rtl/pipe_id_regread.sv | 87 ++++++++
 tb/tb_pipe_id_regread.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_id_regread_pkg.sv
// Shared constants and operand-forwarding encodings for the ID-stage register read block.
package pipe_id_regread_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CNTW = 16;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EALU = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MMEM = 2'b11
  } fwd_sel_e;

  // The EXE producer is younger than the MEM producer, so an EXE hit always wins.
  function automatic fwd_sel_e fwd_select(input logic e_alu_hit,
                                          input logic m_mem_hit,
                                          input logic m_alu_hit);
    fwd_sel_e sel;
    if (e_alu_hit) begin
      sel = FWD_EALU;
    end else if (m_mem_hit) begin
      sel = FWD_MMEM;
    end else if (m_alu_hit) begin
      sel = FWD_MALU;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_id_regread_gpr_file.sv
// General-purpose register file: one write port from WB, two combinational read ports
// with write-through so a same-cycle WB write is visible to the ID-stage reader.
module pipe_gpr_file
  import pipe_id_regread_pkg::*;
#(
  parameter int P_DW = DW,
  parameter int P_AW = AW
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            i_we,
  input  logic [P_AW-1:0] i_wa,
  input  logic [P_DW-1:0] i_wd,
  input  logic [P_AW-1:0] i_ra_a,
  input  logic [P_AW-1:0] i_ra_b,
  output logic [P_DW-1:0] o_qa,
  output logic [P_DW-1:0] o_qb
);

  localparam int NREG = 2 ** P_AW;

  logic [P_DW-1:0] r_gpr [0:NREG-1];

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (i_we && (i_wa != '0)) begin
      r_gpr[i_wa] <= i_wd;
    end else begin
      r_gpr <= r_gpr;
    end
  end

  always_comb begin
    o_qa = '0;
    o_qb = '0;
    if (i_ra_a == '0) begin
      o_qa = '0;
    end else if (i_we && (i_wa == i_ra_a)) begin
      o_qa = i_wd;
    end else begin
      o_qa = r_gpr[i_ra_a];
    end
    if (i_ra_b == '0) begin
      o_qb = '0;
    end else if (i_we && (i_wa == i_ra_b)) begin
      o_qb = i_wd;
    end else begin
      o_qb = r_gpr[i_ra_b];
    end
  end

endmodule

// File: rtl/pipe_id_regread.sv
// ID-stage register read: operands from the GPR file, forwarding selects, load-use
// stall detection and a saturating count of stall cycles.
module pipe_id_regread
  import pipe_id_regread_pkg::*;
#(
  parameter int P_DW   = DW,
  parameter int P_AW   = AW,
  parameter int P_CNTW = CNTW
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [P_AW-1:0]   rs,
  input  logic [P_AW-1:0]   rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic [P_AW-1:0]   ern,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [P_AW-1:0]   mrn,
  input  logic              wwreg,
  input  logic [P_AW-1:0]   wrn,
  input  logic [P_DW-1:0]   wdi,
  output logic [P_DW-1:0]   qa,
  output logic [P_DW-1:0]   qb,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              wpcir,
  output logic [P_CNTW-1:0] stall_cnt
);

  logic              w_e_alu_live;
  logic              w_e_load_live;
  logic              w_m_alu_live;
  logic              w_m_load_live;
  logic              w_stall;
  fwd_sel_e          w_fwda;
  fwd_sel_e          w_fwdb;
  logic [P_CNTW-1:0] r_stall_cnt;

  pipe_gpr_file #(
    .P_DW (P_DW),
    .P_AW (P_AW)
  ) u_gpr (
    .clk    (clk),
    .clrn   (clrn),
    .i_we   (wwreg),
    .i_wa   (wrn),
    .i_wd   (wdi),
    .i_ra_a (rs),
    .i_ra_b (rt),
    .o_qa   (qa),
    .o_qb   (qb)
  );

  always_comb begin
    w_e_alu_live  = ewreg && !em2reg && (ern != '0);
    w_e_load_live = ewreg &&  em2reg && (ern != '0);
    w_m_alu_live  = mwreg && !mm2reg && (mrn != '0);
    w_m_load_live = mwreg &&  mm2reg && (mrn != '0);
    w_fwda  = fwd_select(w_e_alu_live && (ern == rs),
                         w_m_load_live && (mrn == rs),
                         w_m_alu_live && (mrn == rs));
    w_fwdb  = fwd_select(w_e_alu_live && (ern == rt),
                         w_m_load_live && (mrn == rt),
                         w_m_alu_live && (mrn == rt));
    w_stall = w_e_load_live && ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
  end

  assign fwda      = w_fwda;
  assign fwdb      = w_fwdb;
  assign wpcir     = !w_stall;
  assign stall_cnt = r_stall_cnt;

  // Saturates at all-ones so a long stall never reads back as a small count.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(P_CNTW-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_id_regread.sv
// Randomized bench for pipe_id_regread against an array-based reference model,
// plus directed literal checks for reset, write-through, forwarding and stall counting.
module tb_pipe_id_regread;

  localparam int CNT_MAX = 65535;

  logic        clk;
  logic        clrn;
  logic [4:0]  rs, rt, ern, mrn, wrn;
  logic        use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, wwreg;
  logic [31:0] wdi;
  logic [31:0] qa, qb;
  logic [1:0]  fwda, fwdb;
  logic        wpcir;
  logic [15:0] stall_cnt;

  int checks;
  int failures;

  logic [31:0] mdl_gpr [32];
  int unsigned mdl_cnt;

  pipe_id_regread dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .wwreg(wwreg), .wrn(wrn), .wdi(wdi), .qa(qa), .qb(qb), .fwda(fwda), .fwdb(fwdb),
    .wpcir(wpcir), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wwreg && wrn == a) return wdi;
    return mdl_gpr[a];
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (ewreg && !em2reg && ern != 5'd0 && ern == src) return 2'b01;
    if (mwreg &&  mm2reg && mrn != 5'd0 && mrn == src) return 2'b11;
    if (mwreg && !mm2reg && mrn != 5'd0 && mrn == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    return ewreg && em2reg && ern != 5'd0 &&
           ((use_rs && ern == rs) || (use_rt && ern == rt));
  endfunction

  // Reference state: register contents and stall count, cleared by reset.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) mdl_gpr[i] <= 32'd0;
      mdl_cnt <= 0;
    end else begin
      if (wwreg && wrn != 5'd0) mdl_gpr[wrn] <= wdi;
      if (exp_stall() && mdl_cnt != CNT_MAX) mdl_cnt <= mdl_cnt + 1;
    end
  end

  // Per-cycle compare on the falling edge; forwarding is don't-care during a stall.
  always @(negedge clk) begin
    chk("qa_model", qa, exp_read(rs));
    chk("qb_model", qb, exp_read(rt));
    chk("wpcir_model", {31'd0, wpcir}, {31'd0, !exp_stall()});
    chk("stall_cnt_model", {16'd0, stall_cnt}, mdl_cnt);
    if (!exp_stall()) begin
      chk("fwda_model", {30'd0, fwda}, {30'd0, exp_fwd(rs)});
      chk("fwdb_model", {30'd0, fwdb}, {30'd0, exp_fwd(rt)});
    end
  end

  task automatic idle();
    rs = 5'd0; rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
    mwreg = 1'b0; mm2reg = 1'b0; mrn = 5'd0;
    wwreg = 1'b0; wrn = 5'd0; wdi = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    clrn = 1'b1;
    idle();
    rs = 5'd5; rt = 5'd31;
    #1 clrn = 1'b0;
    #2;
    chk("reset_qa", qa, 32'd0);
    chk("reset_qb", qb, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_wpcir", {31'd0, wpcir}, 32'd1);
    tick();
    clrn = 1'b1;

    wwreg = 1'b1; wrn = 5'd3; wdi = 32'hDEADBEEF; rs = 5'd3;
    #1 chk("wt_same_cycle", qa, 32'hDEADBEEF);
    tick();
    wwreg = 1'b0; wdi = 32'd0;
    #1 chk("wt_after_edge", qa, 32'hDEADBEEF);

    wwreg = 1'b1; wrn = 5'd0; wdi = 32'h1234; rs = 5'd0;
    #1 chk("r0_write_through", qa, 32'd0);
    tick();
    wwreg = 1'b0; rs = 5'd0; rt = 5'd3;
    #1 chk("r0_read", qa, 32'd0);
    chk("r3_kept", qb, 32'hDEADBEEF);

    ern = 5'd7; mrn = 5'd7; ewreg = 1'b1; mwreg = 1'b1; em2reg = 1'b0; mm2reg = 1'b1; rs = 5'd7;
    #1 chk("fwd_exe_wins", {30'd0, fwda}, 32'd1);
    ewreg = 1'b0;
    #1 chk("fwd_mem_load", {30'd0, fwda}, 32'd3);
    mm2reg = 1'b0;
    #1 chk("fwd_mem_alu", {30'd0, fwda}, 32'd2);
    tick();

    idle();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd9; rt = 5'd9; use_rt = 1'b1;
    #1 chk("stall_wpcir", {31'd0, wpcir}, 32'd0);
    chk("stall_cnt0", {16'd0, stall_cnt}, 32'd0);
    tick();
    chk("stall_cnt1", {16'd0, stall_cnt}, 32'd1);
    use_rt = 1'b0;
    #1 chk("stall_release", {31'd0, wpcir}, 32'd1);
    tick();

    for (int n = 0; n < 3000; n++) begin
      clrn   = ($urandom_range(0, 199) != 0);
      rs     = rnd_reg();
      rt     = rnd_reg();
      use_rs = 1'($urandom_range(0, 1));
      use_rt = 1'($urandom_range(0, 1));
      ewreg  = 1'($urandom_range(0, 1));
      em2reg = 1'($urandom_range(0, 1));
      ern    = rnd_reg();
      mwreg  = 1'($urandom_range(0, 1));
      mm2reg = 1'($urandom_range(0, 1));
      mrn    = rnd_reg();
      wwreg  = ($urandom_range(0, 3) != 0);
      wrn    = rnd_reg();
      wdi    = $urandom;
      tick();
    end
    clrn = 1'b1;

    idle();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd9; rs = 5'd9; use_rs = 1'b1;
    repeat (65539) @(posedge clk);
    #1 chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_wpcir", {31'd0, wpcir}, 32'd0);
    clrn = 1'b0;
    #1 chk("reset_mid_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_mid_qa", qa, 32'd0);
    tick();
    clrn = 1'b1;
    idle();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
